fetch_decode_stage: RTL and testbench
=====================================

FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning cycles without IMemAck before a fetch error (used only under REQ-024).
REQ-003 SHALL have port CLK  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_L  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port IMemAddr  output  64  meaning the fetch address (current PC).
REQ-006 SHALL have port IMemReq  output  1  meaning fetch request to instruction memory.
REQ-007 SHALL have port IMemAck  input  1  meaning IMemData is valid this cycle.
REQ-008 SHALL have port IMemData  input  32  meaning the fetched instruction word.
REQ-009 SHALL have port Redirect  input  1  meaning the branch/flush request.
REQ-010 SHALL have port RedirectPC  input  64  meaning the new PC on Redirect.
REQ-011 SHALL have port InstrValid  output  1  meaning Instruction, InstrPC, Imm26 and SignExtCtrl are valid.
REQ-012 SHALL have port InstrReady  input  1  meaning the downstream stage accepts this cycle.
REQ-013 SHALL have ports Instruction output 32, InstrPC output 64, Imm26 output 26 (Instruction[25:0]) and SignExtCtrl output 3, all feeding the sign extender and decode.
REQ-014 SHALL have port FetchErr  output  1  meaning sticky fetch-timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, HOLD, ERR; IDLE lasts exactly one cycle after reset release, then REQ.
REQ-016 In REQ: IMemReq=1 and IMemAddr=PC, held stable until IMemAck=1.
REQ-017 On REQ with IMemAck=1: register IMemData into Instruction, PC into InstrPC, decoded SignExtCtrl; PC<=PC+4 (64-bit, wrap modulo 2^64); next state HOLD.
REQ-018 In HOLD: InstrValid=1, outputs stable; on InstrValid&&InstrReady next state REQ, InstrValid=0 next cycle; minimum two cycles per instruction.
REQ-019 Redirect SHALL have priority in every state: PC<=RedirectPC with bits [1:0] forced 0, InstrValid<=0, any same-cycle IMemAck data discarded, FetchErr cleared, next state REQ.
REQ-020 SignExtCtrl decode from the captured word: [31:22]=1001000100 or 1101000100 -> 001; [31:24]=10110100 or 10110101 -> 010; [31:26]=000101 -> 011; [31:21]=11111000010 or 11111000000 -> 000; [31:23]=110100101 -> {1, [22:21]}; all others -> 000.
REQ-021 IMemAck outside REQ SHALL be ignored.

Reset
REQ-022 While Reset_L=0: PC=RESET_PC, state IDLE, IMemReq=0, IMemAddr=RESET_PC, InstrValid=0, Instruction=0, InstrPC=0, SignExtCtrl=000, FetchErr=0, timeout counter=0.
REQ-023 Reset asserted mid-fetch or mid-HOLD SHALL abandon the transaction immediately; no partial capture survives.

Configuration
REQ-024 With IFETCH_TIMEOUT_EN defined: a counter counts consecutive REQ cycles without IMemAck (cleared on ack, Redirect, leaving REQ); on reaching TIMEOUT_CYCLES, IMemReq drops, FetchErr<=1, state ERR until Redirect or reset.
REQ-025 Without IFETCH_TIMEOUT_EN: no counter, ERR unreachable, FetchErr tied 0, REQ waits indefinitely.

Verification
REQ-026 Reset release, memory acks after 1 cycle with 0x91000421, InstrReady=1 -> IMemAddr=0x0, InstrValid=1 with SignExtCtrl=001, InstrPC=0x0; next fetch IMemAddr=0x4.
REQ-027 HOLD with InstrReady=0 for 5 cycles carrying 0xD2A00020 -> InstrValid stays 1, SignExtCtrl=101, Imm26=0x2A00020 stable; no IMemReq.
REQ-028 Redirect=1, RedirectPC=0x1003 in same cycle as IMemAck -> data dropped, InstrValid=0, next IMemAddr=0x1000.
REQ-029 PC=0xFFFF_FFFF_FFFF_FFFC fetch acked -> next IMemAddr=0x0.
REQ-030 With IFETCH_TIMEOUT_EN, no ack for 16 REQ cycles -> FetchErr=1, IMemReq=0; Redirect to 0x40 -> FetchErr=0, IMemAddr=0x40; without macro FetchErr stays 0 and IMemReq stays 1.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//   Single-outstanding instruction fetch with a one-entry decode holding
//   register. The PC is presented to instruction memory, the acknowledged
//   word is captured together with its PC and a sign-extension control code,
//   and the captured instruction is offered downstream until accepted.
//   A redirect (branch/flush) overrides every state and restarts fetching
//   at the word-aligned RedirectPC.
//
// Build option:
//   IFETCH_TIMEOUT_EN - when defined, a fetch that sees no IMemAck for
//                       TIMEOUT_CYCLES consecutive request cycles stops
//                       requesting, raises the sticky FetchErr and parks
//                       until Redirect or reset. When undefined, fetches
//                       wait indefinitely and FetchErr is constant 0.
//
// Ports:
//   CLK          in   clock, all state on rising edge
//   Reset_L      in   asynchronous active-low reset
//   IMemAddr     out  [63:0] fetch address (current PC)
//   IMemReq      out  fetch request
//   IMemAck      in   IMemData valid this cycle
//   IMemData     in   [31:0] fetched instruction word
//   Redirect     in   branch/flush request
//   RedirectPC   in   [63:0] new PC (bits [1:0] ignored)
//   InstrValid   out  captured instruction outputs valid
//   InstrReady   in   downstream accepts this cycle
//   Instruction  out  [31:0] captured instruction word
//   InstrPC      out  [63:0] PC of the captured instruction
//   Imm26        out  [25:0] Instruction[25:0]
//   SignExtCtrl  out  [2:0] sign-extender control code
//   FetchErr     out  sticky fetch-timeout flag
module fetch_decode_stage #(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic [63:0] IMemAddr,
  output logic        IMemReq,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instruction,
  output logic [63:0] InstrPC,
  output logic [25:0] Imm26,
  output logic [2:0]  SignExtCtrl,
  output logic        FetchErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q,    pc_d;
  logic        req_q,   req_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] ipc_q,   ipc_d;
  logic [2:0]  sext_q,  sext_d;

`ifdef IFETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter reaches TIMEOUT_CYCLES-1 on the last ack-less request cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Sign-extension control from the top bits of an instruction word.
  // Earlier patterns take priority over later ones.
  function automatic logic [2:0] decode_sext(input logic [31:0] w);
    logic [2:0] c;
    c = 3'b000;
    if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
      c = 3'b001;
    end else if (w[31:24] == 8'b10110100 || w[31:24] == 8'b10110101) begin
      c = 3'b010;
    end else if (w[31:26] == 6'b000101) begin
      c = 3'b011;
    end else if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
      c = 3'b000;
    end else if (w[31:23] == 9'b110100101) begin
      c = {1'b1, w[22:21]};
    end
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    sext_d  = sext_q;
`ifdef IFETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    if (Redirect) begin
      // Redirect wins over everything, including a same-cycle ack.
      state_d = REQ;
      pc_d    = {RedirectPC[63:2], 2'b00};
      valid_d = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      cnt_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = REQ;
        end
        REQ: begin
          if (IMemAck) begin
            instr_d = IMemData;
            ipc_d   = pc_q;
            sext_d  = decode_sext(IMemData);
            pc_d    = pc_q + 64'd4;
            valid_d = 1'b1;
            state_d = HOLD;
`ifdef IFETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_d = ERR;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (InstrReady) begin
            valid_d = 1'b0;
            state_d = REQ;
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Request is registered alongside the state it belongs to.
    req_d = (state_d == REQ);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      sext_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      sext_q  <= sext_d;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign FetchErr = err_q;
`else
  assign FetchErr = 1'b0;
`endif

  assign IMemAddr    = pc_q;
  assign IMemReq     = req_q;
  assign InstrValid  = valid_q;
  assign Instruction = instr_q;
  assign InstrPC     = ipc_q;
  assign Imm26       = instr_q[25:0];
  assign SignExtCtrl = sext_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
module tb_fetch_decode_stage;

  localparam int unsigned TO = 16;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [63:0] IMemAddr;
  logic        IMemReq;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instruction;
  logic [63:0] InstrPC;
  logic [25:0] Imm26;
  logic [2:0]  SignExtCtrl;
  logic        FetchErr;

  fetch_decode_stage #(
    .RESET_PC      (64'h0),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .IMemAddr   (IMemAddr),
    .IMemReq    (IMemReq),
    .IMemAck    (IMemAck),
    .IMemData   (IMemData),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Instruction(Instruction),
    .InstrPC    (InstrPC),
    .Imm26      (Imm26),
    .SignExtCtrl(SignExtCtrl),
    .FetchErr   (FetchErr)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Transaction-level reference: where the PC is, whether a fetch is
  // outstanding, what instruction is being offered, and the error flag.
  bit          m_idle, m_fetch, m_valid, m_err;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr;
  logic [2:0]  m_sext;
  int unsigned m_wait;

  // Decode rules as (prefix width, prefix value, code), first match wins.
  localparam int unsigned RW[7] = '{10, 10, 8, 8, 6, 11, 11};
  localparam int unsigned RV[7] = '{'h244, 'h344, 'hB4, 'hB5, 'h05, 'h7C2, 'h7C0};
  localparam int unsigned RC[7] = '{1, 1, 2, 2, 3, 0, 0};

  function automatic logic [2:0] ref_sext(input logic [31:0] w);
    for (int i = 0; i < 7; i++) begin
      if (32'(w >> (32 - RW[i])) == RV[i]) return 3'(RC[i]);
    end
    if (32'(w >> 23) == 32'h1A5) return 3'(4 + ((w >> 21) & 32'd3));
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle  = 1'b1;
    m_fetch = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_pc    = 64'h0;
    m_ipc   = 64'h0;
    m_instr = 32'h0;
    m_sext  = 3'd0;
    m_wait  = 0;
  endtask

  task automatic model_edge();
    if (Redirect) begin
      m_pc    = {RedirectPC[63:2], 2'b00};
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_fetch = 1'b1;
      m_idle  = 1'b0;
      m_wait  = 0;
    end else if (m_idle) begin
      m_idle  = 1'b0;
      m_fetch = 1'b1;
    end else if (m_fetch) begin
      if (IMemAck) begin
        m_instr = IMemData;
        m_ipc   = m_pc;
        m_sext  = ref_sext(IMemData);
        m_pc    = m_pc + 64'd4;
        m_fetch = 1'b0;
        m_valid = 1'b1;
        m_wait  = 0;
      end else begin
        m_wait++;
`ifdef IFETCH_TIMEOUT_EN
        if (m_wait == TO) begin
          m_fetch = 1'b0;
          m_err   = 1'b1;
          m_wait  = 0;
        end
`endif
      end
    end else if (m_valid && InstrReady) begin
      m_valid = 1'b0;
      m_fetch = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("addr",  IMemAddr,    m_pc);
    chk("req",   64'(IMemReq),    64'(m_fetch));
    chk("valid", 64'(InstrValid), 64'(m_valid));
    chk("err",   64'(FetchErr),   64'(m_err));
    chk("instr", 64'(Instruction), 64'(m_instr));
    chk("ipc",   InstrPC,     m_ipc);
    chk("imm26", 64'(Imm26),  64'(m_instr[25:0]));
    chk("sext",  64'(SignExtCtrl), 64'(m_sext));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  IMemAddr, 64'h0);
    chk({tag, "_req"},   64'(IMemReq), 64'h0);
    chk({tag, "_valid"}, 64'(InstrValid), 64'h0);
    chk({tag, "_instr"}, 64'(Instruction), 64'h0);
    chk({tag, "_ipc"},   InstrPC, 64'h0);
    chk({tag, "_sext"},  64'(SignExtCtrl), 64'h0);
    chk({tag, "_err"},   64'(FetchErr), 64'h0);
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  logic [31:0] pool [6];

  initial begin
    pool[0] = 32'h91000421;
    pool[1] = 32'hD2A00020;
    pool[2] = 32'hB4000000;
    pool[3] = 32'h14000010;
    pool[4] = 32'hF8400000;
    pool[5] = 32'hD1000000;

    Reset_L    = 1'b0;
    IMemAck    = 1'b0;
    IMemData   = 32'h0;
    Redirect   = 1'b0;
    RedirectPC = 64'h0;
    InstrReady = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    Reset_L = 1'b1;
    model_reset();

    // Idle cycle, then first request cycle without ack.
    step();
    chk("first_req", 64'(IMemReq), 64'h1);
    step();

    // Ack with a sign-extend class 001 word, downstream ready.
    IMemAck    = 1'b1;
    IMemData   = 32'h91000421;
    InstrReady = 1'b1;
    step();
    chk("r26_valid", 64'(InstrValid), 64'h1);
    chk("r26_sext",  64'(SignExtCtrl), 64'h1);
    chk("r26_ipc",   InstrPC, 64'h0);
    IMemAck = 1'b0;
    step();
    chk("r26_next_addr", IMemAddr, 64'h4);

    // Stall in HOLD for five cycles.
    IMemAck    = 1'b1;
    IMemData   = 32'hD2A00020;
    InstrReady = 1'b0;
    step();
    IMemAck = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("r27_valid", 64'(InstrValid), 64'h1);
      chk("r27_sext",  64'(SignExtCtrl), 64'h5);
      chk("r27_imm",   64'(Imm26), 64'h2A00020);
      chk("r27_noreq", 64'(IMemReq), 64'h0);
    end
    InstrReady = 1'b1;
    step();

    // Redirect in the same cycle as an ack drops the data.
    IMemAck    = 1'b1;
    IMemData   = 32'h12345678;
    Redirect   = 1'b1;
    RedirectPC = 64'h1003;
    step();
    chk("r28_valid", 64'(InstrValid), 64'h0);
    chk("r28_addr",  IMemAddr, 64'h1000);
    Redirect = 1'b0;
    IMemAck  = 1'b0;

    // PC wraps past the top of the address space.
    Redirect   = 1'b1;
    RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    Redirect = 1'b0;
    IMemAck  = 1'b1;
    IMemData = 32'h14000010;
    step();
    chk("r29_ipc",  InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("r29_sext", 64'(SignExtCtrl), 64'h3);
    IMemAck = 1'b0;
    step();
    chk("r29_wrap", IMemAddr, 64'h0);

    // No ack for the timeout window.
    repeat (TO) step();
`ifdef IFETCH_TIMEOUT_EN
    chk("r30_err",   64'(FetchErr), 64'h1);
    chk("r30_noreq", 64'(IMemReq), 64'h0);
`else
    chk("r30_err",   64'(FetchErr), 64'h0);
    chk("r30_req",   64'(IMemReq), 64'h1);
`endif
    IMemAck = 1'b1;
    repeat (3) step();
    IMemAck    = 1'b0;
    Redirect   = 1'b1;
    RedirectPC = 64'h40;
    step();
    chk("r30_clr",  64'(FetchErr), 64'h0);
    chk("r30_addr", IMemAddr, 64'h40);
    Redirect = 1'b0;

    // Reset asserted mid-fetch: outputs clear immediately.
    step();
    IMemAck  = 1'b1;
    IMemData = 32'hB4000000;
    #2;
    Reset_L = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge CLK);
    #1;
    check_reset_outputs("held_rst");
    Reset_L = 1'b1;
    IMemAck = 1'b0;
    model_reset();

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      if ((i % 100) < 70) IMemAck = ($urandom_range(0, 1) == 1);
      else                IMemAck = ($urandom_range(0, 19) == 0);
      IMemData   = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : $urandom;
      InstrReady = ($urandom_range(0, 1) == 1);
      Redirect   = ($urandom_range(0, 19) == 0);
      RedirectPC = {$urandom, $urandom};
      step();
      if (i == 200) begin
        Reset_L = 1'b0;
        #1;
        check_reset_outputs("rand_rst");
        @(posedge CLK);
        #1;
        Reset_L = 1'b1;
        model_reset();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
